// File: rtl/axi_stream_remove_header.sv
`default_nettype none
// ============================================================================
// axi_stream_remove_header: strips N leading header bytes from each AXI-Stream
// packet, realigns the payload to beat boundaries, reports the header bytes.
// Revision: 1.0
// ============================================================================
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    hdr_valid,
  output logic [DATA_WD-1:0]      hdr_data,
  output logic [DATA_BYTE_WD-1:0] hdr_keep
);

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

  localparam logic [DATA_BYTE_WD-1:0] C_KEEP_ALL = '1;

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  n_q, n_d;
  logic [DATA_WD-1:0]      resid_q, resid_d;
  logic [DATA_BYTE_WD-1:0] flush_keep_q, flush_keep_d;
  logic                    valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    last_out_q, last_out_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

  logic                    w_out_free;
  logic                    w_in_fire;
  logic [DATA_WD-1:0]      w_kmask;
  logic [DATA_WD-1:0]      w_din;
  logic [DATA_WD-1:0]      w_head;
  logic [DATA_WD-1:0]      w_tail;
  logic [DATA_BYTE_WD-1:0] w_tail_keep;
  logic [DATA_BYTE_WD-1:0] w_last_keep;
  logic                    w_emit;
  logic [DATA_WD-1:0]      w_emit_data;
  logic [DATA_BYTE_WD-1:0] w_emit_keep;
  logic                    w_emit_last;

  assign w_out_free   = !valid_out_q || ready_out;
  assign ready_in     = ((state_q == FIRST) || (state_q == STREAM)) && w_out_free;
  assign ready_remove = (state_q == IDLE) && !valid_out_q;
  assign w_in_fire    = valid_in && ready_in;

  // Invalid bytes of the last beat are zeroed so they never leak to the outputs.
  always_comb begin
    w_kmask = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      w_kmask[8*i +: 8] = {8{keep_in[i]}};
    end
  end

  assign w_din       = last_in ? (data_in & w_kmask) : data_in;
  assign w_head      = (n_q == '0) ? '0 : (w_din >> (8 * (DATA_BYTE_WD - int'(n_q))));
  assign w_tail      = w_din << (8 * int'(n_q));
  assign w_tail_keep = keep_in << n_q;
  assign w_last_keep = (C_KEEP_ALL << n_q) | (keep_in >> (DATA_BYTE_WD - int'(n_q)));

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    resid_d      = resid_q;
    flush_keep_d = flush_keep_q;
    hdr_valid_d  = 1'b0;
    hdr_data_d   = hdr_data_q;
    hdr_keep_d   = hdr_keep_q;
    w_emit       = 1'b0;
    w_emit_data  = '0;
    w_emit_keep  = '0;
    w_emit_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_remove && ready_remove) begin
          n_d     = byte_remove_cnt;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (w_in_fire) begin
          hdr_valid_d = 1'b1;
          hdr_data_d  = w_head;
          hdr_keep_d  = ~(C_KEEP_ALL << n_q);
          resid_d     = w_tail;
          if (last_in) begin
            state_d = IDLE;
            if (w_tail_keep != '0) begin
              w_emit      = 1'b1;
              w_emit_data = w_tail;
              w_emit_keep = w_tail_keep;
              w_emit_last = 1'b1;
            end
          end else begin
            state_d = STREAM;
            if (n_q == '0) begin
              w_emit      = 1'b1;
              w_emit_data = w_din;
              w_emit_keep = C_KEEP_ALL;
            end
          end
        end
      end
      STREAM: begin
        if (w_in_fire) begin
          w_emit = 1'b1;
          if (n_q == '0) begin
            w_emit_data = w_din;
            w_emit_keep = last_in ? keep_in : C_KEEP_ALL;
            w_emit_last = last_in;
            if (last_in) state_d = IDLE;
          end else if (!last_in) begin
            w_emit_data = resid_q | w_head;
            w_emit_keep = C_KEEP_ALL;
            resid_d     = w_tail;
          end else if (w_tail_keep == '0) begin
            w_emit_data = resid_q | w_head;
            w_emit_keep = w_last_keep;
            w_emit_last = 1'b1;
            state_d     = IDLE;
          end else begin
            // Last beat spills past this output beat; the tail goes out from FLUSH.
            w_emit_data  = resid_q | w_head;
            w_emit_keep  = C_KEEP_ALL;
            resid_d      = w_tail;
            flush_keep_d = w_tail_keep;
            state_d      = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_emit      = 1'b1;
          w_emit_data = resid_q;
          w_emit_keep = flush_keep_q;
          w_emit_last = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    if (w_emit) begin
      valid_out_d = 1'b1;
      data_out_d  = w_emit_data;
      keep_out_d  = w_emit_keep;
      last_out_d  = w_emit_last;
    end else if (ready_out) begin
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      resid_q      <= '0;
      flush_keep_q <= '0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      keep_out_q   <= '0;
      last_out_q   <= 1'b0;
      hdr_valid_q  <= 1'b0;
      hdr_data_q   <= '0;
      hdr_keep_q   <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      resid_q      <= resid_d;
      flush_keep_q <= flush_keep_d;
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
      keep_out_q   <= keep_out_d;
      last_out_q   <= last_out_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_data_q   <= hdr_data_d;
      hdr_keep_q   <= hdr_keep_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;
  assign hdr_valid = hdr_valid_q;
  assign hdr_data  = hdr_data_q;
  assign hdr_keep  = hdr_keep_q;

endmodule
`default_nettype wire
